prbs_loopback_checker: RTL and testbench

- Synthesizable, self-synchronizing PRBS checker for the loopback path.
- Consumes N recovered bits per word from the unfolded TI-ADC output, in the clk_adc domain.
- Acquires lock automatically, then accumulates error and bit counts for JTAG readout.
- Replaces the simulation-only TX/ADC recorder flow with on-chip BER measurement, selectable across four PRBS orders.

---
 rtl/prbs_loopback_checker.sv | 187 ++++++++++++++++++
 tb/tb_prbs_loopback_checker.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_loopback_checker.sv
// rtl/prbs_loopback_checker.sv - self-synchronizing PRBS loopback checker with BER counters
module prbs_loopback_checker #(
   parameter int N        = 16,
   parameter int ERR_W    = 32,
   parameter int LOCK_CYC = 16,
   parameter int LOSS_CYC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       prbs_sel,
   input  logic             clear,
   input  logic             data_valid,
   input  logic [N-1:0]     data_in,
   output logic             locked,
   output logic [N-1:0]     err_word,
   output logic [ERR_W-1:0] err_count,
   output logic [ERR_W-1:0] bit_count,
   output logic             err_sat,
   output logic             bit_sat
);
   localparam int HW   = 31;
   localparam int SW   = HW + N;
   localparam int PC_W = $clog2(N + 1);
   localparam int CC_W = $clog2(LOCK_CYC + 1);
   localparam int BC_W = $clog2(LOSS_CYC + 1);

   typedef enum logic [1:0] {ST_DISABLED, ST_HUNT, ST_LOCKED} state_t;

   state_t           state_q, state_d;
   logic [HW-1:0]    hist_q, hist_d;
   logic [1:0]       sel_q, sel_d;
   logic [CC_W-1:0]  clean_cnt_q, clean_cnt_d;
   logic [BC_W-1:0]  bad_cnt_q, bad_cnt_d;
   logic [N-1:0]     err_word_q, err_word_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic [ERR_W-1:0] bit_count_q, bit_count_d;
   logic             err_sat_q, err_sat_d;
   logic             bit_sat_q, bit_sat_d;
   logic             locked_q;

   logic [SW-1:0]    stream;
   logic [N-1:0]     e7, e9, e15, e31, err;
   logic [PC_W-1:0]  pc;
   logic             clean, bad;
   logic [ERR_W:0]   err_sum, bit_sum;
   logic             err_full, bit_full;

   // Oldest history bit sits at stream[0]; data_in[0] follows the newest history bit.
   assign stream = {data_in, hist_q};

   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_tap
         assign e7[i]  = stream[HW+i] ^ stream[HW+i-6]  ^ stream[HW+i-7];
         assign e9[i]  = stream[HW+i] ^ stream[HW+i-5]  ^ stream[HW+i-9];
         assign e15[i] = stream[HW+i] ^ stream[HW+i-14] ^ stream[HW+i-15];
         assign e31[i] = stream[HW+i] ^ stream[HW+i-28] ^ stream[HW+i-31];
      end
   endgenerate

   always_comb begin
      err = e7;
      case (prbs_sel)
         2'd0: err = e7;
         2'd1: err = e9;
         2'd2: err = e15;
         2'd3: err = e31;
      endcase
      pc = '0;
      for (int k = 0; k < N; k++) pc = pc + PC_W'(err[k]);
   end

   assign clean    = (pc == '0) && (|data_in);
   assign bad      = (pc > PC_W'(N / 4));
   assign err_sum  = {1'b0, err_count_q} + (ERR_W+1)'(pc);
   assign bit_sum  = {1'b0, bit_count_q} + (ERR_W+1)'(N);
   assign err_full = err_sum[ERR_W] | (&err_sum[ERR_W-1:0]);
   assign bit_full = bit_sum[ERR_W] | (&bit_sum[ERR_W-1:0]);

   always_comb begin
      state_d     = state_q;
      hist_d      = hist_q;
      sel_d       = sel_q;
      clean_cnt_d = clean_cnt_q;
      bad_cnt_d   = bad_cnt_q;
      err_word_d  = err_word_q;
      err_count_d = err_count_q;
      bit_count_d = bit_count_q;
      err_sat_d   = err_sat_q;
      bit_sat_d   = bit_sat_q;
      if (data_valid) begin
         hist_d     = stream[SW-1:N];
         err_word_d = err;
         sel_d      = prbs_sel;
         if (!en) begin
            state_d     = ST_DISABLED;
            clean_cnt_d = '0;
            bad_cnt_d   = '0;
         end else if (prbs_sel != sel_q) begin
            state_d     = ST_HUNT;
            clean_cnt_d = '0;
            bad_cnt_d   = '0;
         end else begin
            case (state_q)
               ST_DISABLED: begin
                  state_d     = ST_HUNT;
                  clean_cnt_d = '0;
                  bad_cnt_d   = '0;
               end
               ST_HUNT: begin
                  if (!clean) begin
                     clean_cnt_d = '0;
                  end else if (clean_cnt_q == CC_W'(LOCK_CYC - 1)) begin
                     state_d     = ST_LOCKED;
                     clean_cnt_d = '0;
                     bad_cnt_d   = '0;
                     err_count_d = '0;
                     bit_count_d = '0;
                     err_sat_d   = 1'b0;
                     bit_sat_d   = 1'b0;
                  end else begin
                     clean_cnt_d = clean_cnt_q + CC_W'(1);
                  end
               end
               ST_LOCKED: begin
                  err_count_d = err_full ? '1 : err_sum[ERR_W-1:0];
                  bit_count_d = bit_full ? '1 : bit_sum[ERR_W-1:0];
                  err_sat_d   = err_sat_q | err_full;
                  bit_sat_d   = bit_sat_q | bit_full;
                  if (!bad) begin
                     bad_cnt_d = '0;
                  end else if (bad_cnt_q == BC_W'(LOSS_CYC - 1)) begin
                     state_d   = ST_HUNT;
                     bad_cnt_d = '0;
                  end else begin
                     bad_cnt_d = bad_cnt_q + BC_W'(1);
                  end
               end
               default: state_d = ST_DISABLED;
            endcase
            // Clear wins over both the accumulate and the lock-entry zeroing.
            if (clear) begin
               err_count_d = '0;
               bit_count_d = '0;
               err_sat_d   = 1'b0;
               bit_sat_d   = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_DISABLED;
         hist_q      <= '0;
         sel_q       <= '0;
         clean_cnt_q <= '0;
         bad_cnt_q   <= '0;
         err_word_q  <= '0;
         err_count_q <= '0;
         bit_count_q <= '0;
         err_sat_q   <= 1'b0;
         bit_sat_q   <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         hist_q      <= hist_d;
         sel_q       <= sel_d;
         clean_cnt_q <= clean_cnt_d;
         bad_cnt_q   <= bad_cnt_d;
         err_word_q  <= err_word_d;
         err_count_q <= err_count_d;
         bit_count_q <= bit_count_d;
         err_sat_q   <= err_sat_d;
         bit_sat_q   <= bit_sat_d;
         locked_q    <= (state_d == ST_LOCKED);
      end
   end

   assign locked    = locked_q;
   assign err_word  = err_word_q;
   assign err_count = err_count_q;
   assign bit_count = bit_count_q;
   assign err_sat   = err_sat_q;
   assign bit_sat   = bit_sat_q;
endmodule

// File: tb/tb_prbs_loopback_checker.sv
// tb/tb_prbs_loopback_checker.sv - directed/random bench for prbs_loopback_checker
module tb_prbs_loopback_checker;
   localparam int N = 16;
   localparam longint MAX32 = 64'hFFFF_FFFF;
   localparam longint MAX8  = 255;

   logic         clk = 1'b0;
   logic         rst, en, clear, data_valid;
   logic [1:0]   prbs_sel;
   logic [N-1:0] data_in;

   logic         locked_a, err_sat_a, bit_sat_a;
   logic [N-1:0] err_word_a;
   logic [31:0]  err_count_a, bit_count_a;
   logic         locked_b, err_sat_b, bit_sat_b;
   logic [N-1:0] err_word_b;
   logic [7:0]   err_count_b, bit_count_b;

   prbs_loopback_checker #(.N(N), .ERR_W(32), .LOCK_CYC(16), .LOSS_CYC(4)) u_dut (
      .clk(clk), .rst(rst), .en(en), .prbs_sel(prbs_sel), .clear(clear),
      .data_valid(data_valid), .data_in(data_in), .locked(locked_a),
      .err_word(err_word_a), .err_count(err_count_a), .bit_count(bit_count_a),
      .err_sat(err_sat_a), .bit_sat(bit_sat_a));

   prbs_loopback_checker #(.N(N), .ERR_W(8), .LOCK_CYC(16), .LOSS_CYC(4)) u_dut8 (
      .clk(clk), .rst(rst), .en(en), .prbs_sel(prbs_sel), .clear(clear),
      .data_valid(data_valid), .data_in(data_in), .locked(locked_b),
      .err_word(err_word_b), .err_count(err_count_b), .bit_count(bit_count_b),
      .err_sat(err_sat_b), .bit_sat(bit_sat_b));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: received bits kept in time order, newest at the back.
   bit           rq[$];
   int           m_st;   // 0 disabled, 1 hunt, 2 locked
   int           m_cc, m_bc, m_psel;
   longint       m_ec32, m_bc32, m_ec8, m_bc8;
   bit           m_es32, m_bs32, m_es8, m_bs8;
   logic [N-1:0] m_ew;

   bit           gq[$];
   int           g_sel;

   function automatic void taps_of(input int sel, output int a, output int b);
      case (sel)
         0:       begin a = 6;  b = 7;  end
         1:       begin a = 5;  b = 9;  end
         2:       begin a = 14; b = 15; end
         default: begin a = 28; b = 31; end
      endcase
   endfunction

   task automatic zero_counts();
      m_ec32 = 0; m_bc32 = 0; m_ec8 = 0; m_bc8 = 0;
      m_es32 = 0; m_bs32 = 0; m_es8 = 0; m_bs8 = 0;
   endtask

   task automatic model_reset();
      rq.delete();
      repeat (31) rq.push_back(1'b0);
      m_st = 0; m_cc = 0; m_bc = 0; m_psel = 0; m_ew = '0;
      zero_counts();
   endtask

   task automatic accumulate(input int pc);
      m_ec32 = (m_ec32 + pc >= MAX32) ? MAX32 : m_ec32 + pc;
      m_bc32 = (m_bc32 + N  >= MAX32) ? MAX32 : m_bc32 + N;
      m_ec8  = (m_ec8 + pc  >= MAX8)  ? MAX8  : m_ec8 + pc;
      m_bc8  = (m_bc8 + N   >= MAX8)  ? MAX8  : m_bc8 + N;
      if (m_ec32 == MAX32) m_es32 = 1;
      if (m_bc32 == MAX32) m_bs32 = 1;
      if (m_ec8 == MAX8)   m_es8 = 1;
      if (m_bc8 == MAX8)   m_bs8 = 1;
   endtask

   task automatic model_word(input logic [N-1:0] d);
      int a, b, n, pc;
      logic [N-1:0] e;
      bit cln, bd;
      taps_of(int'(prbs_sel), a, b);
      for (int i = 0; i < N; i++) begin
         rq.push_back(d[i]);
         n = rq.size() - 1;
         e[i] = rq[n] ^ rq[n-a] ^ rq[n-b];
      end
      while (rq.size() > 31) void'(rq.pop_front());
      pc  = $countones(e);
      cln = (pc == 0) && (d != '0);
      bd  = (pc > N / 4);
      m_ew = e;
      if (!en) begin
         m_st = 0; m_cc = 0; m_bc = 0;
      end else if (int'(prbs_sel) != m_psel) begin
         m_st = 1; m_cc = 0; m_bc = 0;
      end else begin
         if (m_st == 0) begin
            m_st = 1; m_cc = 0; m_bc = 0;
         end else if (m_st == 1) begin
            m_cc = cln ? m_cc + 1 : 0;
            if (m_cc == 16) begin m_st = 2; m_cc = 0; zero_counts(); end
         end else begin
            accumulate(pc);
            m_bc = bd ? m_bc + 1 : 0;
            if (m_bc == 4) begin m_st = 1; m_bc = 0; end
         end
         if (clear) zero_counts();
      end
      m_psel = int'(prbs_sel);
   endtask

   task automatic seed_gen(input int sel);
      g_sel = sel;
      gq.delete();
      repeat (30) gq.push_back(1'($urandom));
      gq.push_back(1'b1);
   endtask

   task automatic gen_word(output logic [N-1:0] w);
      int a, b, n;
      bit nb;
      taps_of(g_sel, a, b);
      for (int i = 0; i < N; i++) begin
         n  = gq.size();
         nb = gq[n-a] ^ gq[n-b];
         gq.push_back(nb);
         w[i] = nb;
      end
      while (gq.size() > 31) void'(gq.pop_front());
   endtask

   task automatic compare_all();
      chk("locked_a",    locked_a,    (m_st == 2));
      chk("err_word_a",  err_word_a,  m_ew);
      chk("err_count_a", err_count_a, m_ec32);
      chk("bit_count_a", bit_count_a, m_bc32);
      chk("err_sat_a",   err_sat_a,   m_es32);
      chk("bit_sat_a",   bit_sat_a,   m_bs32);
      chk("locked_b",    locked_b,    (m_st == 2));
      chk("err_count_b", err_count_b, m_ec8);
      chk("bit_count_b", bit_count_b, m_bc8);
      chk("err_sat_b",   err_sat_b,   m_es8);
      chk("bit_sat_b",   bit_sat_b,   m_bs8);
   endtask

   task automatic step(input logic v, input logic [N-1:0] d);
      data_valid = v;
      data_in    = d;
      @(posedge clk);
      if (v) model_word(d);
      #1;
      compare_all();
   endtask

   task automatic gstep(input bit flip, input int pos);
      logic [N-1:0] w;
      gen_word(w);
      if (flip) w[pos] = ~w[pos];
      step(1'b1, w);
   endtask

   task automatic wait_lock(input int bound, output int used);
      used = 0;
      for (int k = 0; k < bound; k++) begin
         gstep(1'b0, 0);
         if (locked_a) begin used = k + 1; break; end
      end
   endtask

   initial begin
      int used, nflip;
      bit seen;
      rst = 1'b1; en = 1'b0; prbs_sel = 2'd0; clear = 1'b0;
      data_valid = 1'b0; data_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      rst = 1'b0;

      // Clean PRBS7 acquisition and accumulation
      en = 1'b1;
      seed_gen(0);
      wait_lock(18, used);
      chk("prbs7_lock_time", (used >= 1 && used <= 17), 1'b1);
      repeat (100) gstep(1'b0, 0);
      chk("bit_count_100w", bit_count_a, 1600);
      chk("err_count_100w", err_count_a, 0);

      // Single bit errors, in-word and straddling the word boundary
      repeat (49) gstep(1'b0, 0);
      gstep(1'b1, 12);
      repeat (2) gstep(1'b0, 0);
      chk("flip_bit12", err_count_a, 3);
      repeat (10) gstep(1'b0, 0);
      gstep(1'b1, 14);
      repeat (2) gstep(1'b0, 0);
      chk("flip_bit14", err_count_a, 6);
      chk("flip_still_locked", locked_a, 1'b1);

      // Asynchronous reset mid-LOCKED
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("rst_locked", locked_a, 1'b0);
      chk("rst_err_count", err_count_a, 0);
      chk("rst_bit_count", bit_count_a, 0);
      chk("rst_err_word", err_word_a, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Degenerate streams must never lock
      seen = 1'b0;
      repeat (1000) begin step(1'b1, '0); if (locked_a) seen = 1'b1; end
      chk("zeros_never_lock", seen, 1'b0);
      seen = 1'b0;
      repeat (1000) begin step(1'b1, '1); if (locked_a) seen = 1'b1; end
      chk("ones_never_lock", seen, 1'b0);

      // PRBS31 lock, then polynomial switch with the stream unchanged
      prbs_sel = 2'd3;
      seed_gen(3);
      wait_lock(40, used);
      chk("prbs31_locked", (used > 0), 1'b1);
      repeat (20) gstep(1'b0, 0);
      prbs_sel = 2'd0;
      gstep(1'b0, 0);
      chk("sel_change_drop", locked_a, 1'b0);
      seen = 1'b0;
      repeat (200) begin gstep(1'b0, 0); if (locked_a) seen = 1'b1; end
      chk("wrong_poly_no_relock", seen, 1'b0);
      chk("held_bit_count", bit_count_a, 320);
      chk("held_err_count", err_count_a, 0);

      seed_gen(0);
      wait_lock(40, used);
      chk("prbs7_relock", (used > 0), 1'b1);
      chk("relock_err_zero", err_count_a, 0);
      chk("relock_bit_zero", bit_count_a, 0);

      // Errors in every other word drive the 8-bit counters into saturation
      nflip = 0;
      for (int k = 0; k < 200; k++) begin
         if (k % 2 == 0) begin
            gstep(1'b1, int'($urandom_range(0, N - 1)));
            nflip++;
         end else begin
            gstep(1'b0, 0);
         end
      end
      chk("sat_locked", locked_a, 1'b1);
      chk("sat_err_count_a", err_count_a, 3 * nflip);
      chk("sat_bit_count_a", bit_count_a, 200 * N);
      chk("sat_bit_count_b", bit_count_b, 255);
      chk("sat_err_count_b", err_count_b, 255);
      chk("sat_bit_flag_b", bit_sat_b, 1'b1);
      chk("sat_err_flag_b", err_sat_b, 1'b1);

      // Clear overrides an accumulate of an errored word
      clear = 1'b1;
      gstep(1'b1, 3);
      clear = 1'b0;
      chk("clear_err_a", err_count_a, 0);
      chk("clear_bit_a", bit_count_a, 0);
      chk("clear_err_b", err_count_b, 0);
      chk("clear_bit_b", bit_count_b, 0);
      chk("clear_sat_b", {err_sat_b, bit_sat_b}, 2'b00);

      // data_valid gap freezes everything, history included
      repeat (2) gstep(1'b0, 0);
      repeat (20) begin
         step(1'b0, N'($urandom));
         chk("gap_bit_hold", bit_count_a, 32);
         chk("gap_lock_hold", locked_a, 1'b1);
      end
      gstep(1'b0, 0);
      chk("resume_clean", err_word_a, 0);
      chk("resume_bit_count", bit_count_a, 48);

      // Disable drops lock and holds the counters
      en = 1'b0;
      gstep(1'b0, 0);
      chk("en0_unlock", locked_a, 1'b0);
      chk("en0_bit_hold", bit_count_a, 48);
      en = 1'b1;
      gstep(1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
